// File: rtl/ubs_count_p.sv
// rtl/ubs_count_p.sv - parallel unary bit-stream counter, p bits per beat
// Accumulates the popcount of 2^width/p beats per frame and presents the total with a one-cycle valid.

module ubs_count_p #(
   parameter int width = 5,
   parameter int p     = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic [p-1:0]     un_data,
   output logic             busy,
   output logic             out_valid,
   output logic [width:0]   count_out
);

   localparam int BEATS = (2 ** width) / p;
   localparam logic [width-1:0] LAST_BEAT = width'(BEATS - 1);

   typedef enum logic {IDLE, ACC} state_t;

   state_t           state, state_n;
   logic [width:0]   acc, acc_n;
   logic [width-1:0] beat, beat_n;
   logic [width:0]   count_n;
   logic             out_valid_n;
   logic [width:0]   pop;

   always_comb begin
      pop = '0;
      for (int i = 0; i < p; i++) begin
         pop = pop + {{width{1'b0}}, un_data[i]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         acc       <= '0;
         beat      <= '0;
         count_out <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_n;
         acc       <= acc_n;
         beat      <= beat_n;
         count_out <= count_n;
         out_valid <= out_valid_n;
      end
   end

   // start always wins: in IDLE it opens a frame, in ACC it discards the current beat and restarts
   always_comb begin
      state_n     = state;
      acc_n       = acc;
      beat_n      = beat;
      count_n     = count_out;
      out_valid_n = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_n = ACC;
               acc_n   = '0;
               beat_n  = '0;
            end
         end
         ACC: begin
            if (start) begin
               acc_n  = '0;
               beat_n = '0;
            end else if (in_valid) begin
               if (beat == LAST_BEAT) begin
                  count_n     = acc + pop;
                  out_valid_n = 1'b1;
                  state_n     = IDLE;
                  acc_n       = '0;
                  beat_n      = '0;
               end else begin
                  acc_n  = acc + pop;
                  beat_n = beat + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state == ACC);

endmodule

// File: tb/tb_ubs_count_p.sv
// tb/tb_ubs_count_p.sv - directed self-checking bench for ubs_count_p
// Default parameters: 16 beats of 2 bits per frame.

module tb_ubs_count_p;

   typedef logic [1:0] stream_t [16];

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [1:0] un_data = 2'b00;
   logic       busy;
   logic       out_valid;
   logic [5:0] count_out;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ov_n = 0;
   int ov_last = 0;
   int ov_prev = 0;
   int ov_base;

   ubs_count_p #(.width(5), .p(2)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .un_data(un_data),
      .busy(busy), .out_valid(out_valid), .count_out(count_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (out_valid) begin
         ov_n    = ov_n + 1;
         ov_prev = ov_last;
         ov_last = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic stream_t mk(input logic [1:0] a, input int na,
                                  input logic [1:0] b, input int nb, input logic [1:0] c);
      stream_t s;
      for (int k = 0; k < 16; k++) s[k] = (k < na) ? a : ((k < na + nb) ? b : c);
      return s;
   endfunction

   // Leaves the bench one step after the edge that accepts the last beat,
   // i.e. inside the cycle where out_valid should be high.
   task automatic run_frame(input stream_t s, input bit gaps, input int exp, input string tag);
      start    = 1'b1;
      in_valid = 1'b0;
      tick();
      start = 1'b0;
      chk({tag, "_busy_start"}, busy, 1);
      for (int k = 0; k < 16; k++) begin
         if (gaps) begin
            repeat ($urandom_range(3)) begin
               in_valid = 1'b0;
               un_data  = 2'b11;
               tick();
            end
         end
         in_valid = 1'b1;
         un_data  = s[k];
         tick();
      end
      in_valid = 1'b0;
      chk({tag, "_out_valid"}, out_valid, 1);
      chk({tag, "_count"}, count_out, exp);
      chk({tag, "_busy_done"}, busy, 0);
   endtask

   initial begin
      repeat (2) tick();
      chk("rst_hold_count", count_out, 0);
      chk("rst_hold_valid", out_valid, 0);
      chk("rst_hold_busy", busy, 0);
      rst = 1'b1;
      in_valid = 1'b1;
      un_data  = 2'b11;
      repeat (3) tick();
      in_valid = 1'b0;
      chk("post_rst_count", count_out, 0);
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_busy", busy, 0);

      ov_base = ov_n;
      run_frame(mk(2'b11, 6, 2'b01, 1, 2'b00), 1'b0, 13, "val13");
      tick();
      chk("val13_pulse_width", out_valid, 0);
      chk("val13_count_hold", count_out, 13);
      chk("val13_pulses", ov_n - ov_base, 1);

      run_frame(mk(2'b00, 16, 2'b00, 0, 2'b00), 1'b0, 0, "zero");
      tick();
      run_frame(mk(2'b11, 16, 2'b00, 0, 2'b00), 1'b0, 32, "full");
      tick();

      ov_base = ov_n;
      run_frame(mk(2'b11, 6, 2'b01, 1, 2'b00), 1'b1, 13, "gaps");
      tick();
      chk("gaps_pulses", ov_n - ov_base, 1);

      // Abort after 8 beats; the beat presented with start is discarded.
      ov_base  = ov_n;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      un_data  = 2'b11;
      repeat (8) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_busy", busy, 1);
      chk("restart_no_valid", out_valid, 0);
      un_data = 2'b01;
      repeat (16) tick();
      in_valid = 1'b0;
      chk("restart_count", count_out, 16);
      chk("restart_valid", out_valid, 1);
      tick();
      chk("restart_pulses", ov_n - ov_base, 1);

      // start coinciding with the would-be last beat produces no result.
      ov_base  = ov_n;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      un_data  = 2'b11;
      repeat (15) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("lastrestart_no_valid", out_valid, 0);
      chk("lastrestart_count_kept", count_out, 16);
      un_data = 2'b00;
      repeat (16) tick();
      in_valid = 1'b0;
      chk("lastrestart_count", count_out, 0);
      tick();
      chk("lastrestart_pulses", ov_n - ov_base, 1);

      // Reset mid-frame: outputs clear without waiting for a clock edge.
      run_frame(mk(2'b11, 6, 2'b01, 1, 2'b00), 1'b0, 13, "pre_rst");
      tick();
      ov_base  = ov_n;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      un_data  = 2'b11;
      repeat (8) tick();
      in_valid = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_count", count_out, 0);
      chk("midrst_valid", out_valid, 0);
      tick();
      rst      = 1'b1;
      in_valid = 1'b1;
      repeat (20) tick();
      in_valid = 1'b0;
      chk("midrst_idle_busy", busy, 0);
      chk("midrst_idle_count", count_out, 0);
      chk("midrst_pulses", ov_n - ov_base, 0);

      // Back-to-back: second start lands in the first out_valid cycle.
      ov_base = ov_n;
      run_frame(mk(2'b11, 2, 2'b01, 1, 2'b00), 1'b0, 5, "b2b_5");
      run_frame(mk(2'b11, 13, 2'b01, 1, 2'b00), 1'b0, 27, "b2b_27");
      tick();
      chk("b2b_pulses", ov_n - ov_base, 2);
      chk("b2b_spacing", ov_last - ov_prev, 17);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
